oled_text_streamer: RTL
=======================

Name: oled_text_streamer

Overview:
- Parametrised successor to the fixed-string OLED sender. Holds a writable character buffer and streams a selectable run of it to oledControl, one byte at a time.
- Uses the existing sendData / sendDataValid / sendDone byte handshake.
- Adds runtime start address and length, circular wrap, a fill mode that sends a pad character (for clearing), abort, and status outputs.
- Sits between application logic and oledControl.

Parameters:
- DEPTH, 64, number of 8-bit character cells in the buffer (power of two, ≥2)
- ADDR_W, 6, buffer address width, equal to log2(DEPTH)
- PAD_CHAR, 8'h20, byte sent for every character when fill_mode is set

Ports:
- clock  in  1  100MHz system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_W  buffer write address
- wr_data  in  8  buffer write data
- start  in  1  one-cycle request to begin a run
- start_addr  in  ADDR_W  first buffer cell of the run, sampled with start
- length  in  ADDR_W+1  number of bytes to send (0..DEPTH), sampled with start
- fill_mode  in  1  1 = send PAD_CHAR for each byte instead of buffer contents; sampled with start
- abort  in  1  request to stop at the next byte boundary
- busy  out  1  high from the cycle after an accepted start until the cycle done or aborted pulses
- done  out  1  one-cycle pulse when a run completes normally
- aborted  out  1  one-cycle pulse when a run ends because of abort
- sent_count  out  ADDR_W+1  bytes completed in the current or last run
- sendData  out  8  byte to oledControl
- sendDataValid  out  1  byte request to oledControl
- sendDone  in  1  byte completion from oledControl

Behaviour:
- Reset (reset_n low, asynchronous):
  - state IDLE
  - busy, done, aborted, sendDataValid = 0
  - sendData = 0, sent_count = 0, abort_pending = 0
  - Buffer contents are not reset.
- Buffer writes:
  - A write occurs when wr_en is high, in any state; busy is ignored.
  - If a write and a byte load hit the same cell in the same cycle, the old value is sent.
- States: IDLE, WAIT_READY, SEND, FINISH.
- IDLE:
  - start=1 and length≠0: latch start_addr into rd_ptr, length into remaining, latch fill_mode, clear sent_count and abort_pending; busy<=1; go to WAIT_READY.
  - start=1 and length=0: go to FINISH with sent_count=0. done pulses 1 cycle after start, busy is never asserted, no bytes are sent.
- start is ignored in every state except IDLE, including the FINISH cycle.
- WAIT_READY:
  - Wait for sendDone=0.
  - Then load sendData <= fill_mode ? PAD_CHAR : buf[rd_ptr], set sendDataValid<=1, go to SEND.
  - Earliest sendDataValid rise is 2 cycles after start.
- SEND:
  - sendData and sendDataValid are held stable until sendDone=1.
  - On sendDone=1: sendDataValid<=0; sent_count+1; rd_ptr+1 mod DEPTH (wraps DEPTH-1 → 0); remaining-1.
  - If remaining was 1 or abort_pending=1, go to FINISH; otherwise go to WAIT_READY.
- abort:
  - abort=1 while busy sets abort_pending.
  - The byte in flight is never truncated; sendDataValid is not dropped before sendDone.
  - If abort arrives in WAIT_READY, no further byte is loaded: WAIT_READY goes straight to FINISH.
  - abort in IDLE has no effect.
- FINISH (1 cycle):
  - busy<=0.
  - done<=1 if the run completed normally; aborted<=1 if abort_pending was set.
  - If abort is raised and the last byte completes in the same cycle, aborted pulses, not done.
  - Next state IDLE.
- Length rules:
  - length > DEPTH is clamped to DEPTH.
  - length = DEPTH with any start_addr sends every cell exactly once, in circular order.
- sent_count holds its value after FINISH until the next accepted start.

Test Plan:
- Write "hi sir" to cells 0..5, start with start_addr=0, length=6, fill_mode=0, responder that returns sendDone 3 cycles after valid → bytes 68,69,20,73,69,72 in order; done pulses once; sent_count=6; busy low afterwards.
- DEPTH=64, start_addr=62, length=4 → cells 62,63,0,1 sent in that order (wrap check).
- fill_mode=1, length=64 → 64 bytes of 8'h20; buffer contents unused; done pulses.
- Assert abort during byte 2 of a 6-byte run → byte 2 completes, no third valid, aborted pulses, done stays 0, sent_count=2.
- length=0 start → done pulses 1 cycle later, sendDataValid never high; a start while busy is ignored and the run count is unchanged.
- Drive reset_n low mid-SEND → sendDataValid and busy drop asynchronously, state IDLE; a new start after release runs normally from sent_count=0.

Source files
------------

// File: rtl/oled_text_streamer_if.sv
// -----------------------------------------------------------------------------
// oled_text_streamer_if
// Byte handshake between the text streamer and oledControl.
//   sendData      : byte presented to oledControl            (master -> slave)
//   sendDataValid : byte request, held until sendDone        (master -> slave)
//   sendDone      : byte completion from oledControl         (slave  -> master)
// master modport = streamer side, slave modport = oledControl side.
// -----------------------------------------------------------------------------
interface oled_text_streamer_if;
    logic [7:0] sendData;
    logic       sendDataValid;
    logic       sendDone;

    modport master (
        output sendData,
        output sendDataValid,
        input  sendDone
    );

    modport slave (
        input  sendData,
        input  sendDataValid,
        output sendDone
    );
endinterface

// File: rtl/oled_text_streamer.sv
// -----------------------------------------------------------------------------
// oled_text_streamer
// Writable character buffer that streams a run of cells to oledControl one
// byte at a time over the sendData / sendDataValid / sendDone handshake.
// A run is defined at start time by a start address, a length (clamped to
// DEPTH, wrapping circularly through the buffer) and a fill mode that sends
// PAD_CHAR instead of buffer contents. A run can be aborted at a byte boundary.
//
// Ports:
//   clock, reset_n      : system clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : buffer write port, usable in any state
//   start, start_addr, length, fill_mode : run request (sampled with start)
//   abort               : stop the run at the next byte boundary
//   busy, done, aborted : run status (done/aborted are one-cycle pulses)
//   sent_count          : bytes completed in the current or last run
//   oled                : byte handshake to oledControl (master side)
// -----------------------------------------------------------------------------
module oled_text_streamer #(
    parameter int         DEPTH    = 64,
    parameter int         ADDR_W   = 6,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W:0]       length,
    input  logic                  fill_mode,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_W:0]       sent_count,
    oled_text_streamer_if.master  oled
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_READY = 2'd1,
        ST_SEND       = 2'd2,
        ST_FINISH     = 2'd3
    } state_e;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ZERO_C  = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W - 1){1'b0}}, 1'b1};

    logic [7:0]        mem_q [DEPTH];

    state_e            state_q,         state_d;
    logic [ADDR_W-1:0] rd_ptr_q,        rd_ptr_d;
    logic [ADDR_W:0]   remaining_q,     remaining_d;
    logic              fill_q,          fill_d;
    logic              abort_pending_q, abort_pending_d;
    logic              busy_q,          busy_d;
    logic              done_q,          done_d;
    logic              aborted_q,       aborted_d;
    logic [ADDR_W:0]   sent_count_q,    sent_count_d;
    logic [7:0]        send_data_q,     send_data_d;
    logic              send_valid_q,    send_valid_d;

    logic              abort_now_s;

    // Character buffer write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output logic of the run sequencer.
    always_comb begin
        state_d         = state_q;
        rd_ptr_d        = rd_ptr_q;
        remaining_d     = remaining_q;
        fill_d          = fill_q;
        abort_pending_d = abort_pending_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        aborted_d       = 1'b0;
        sent_count_d    = sent_count_q;
        send_data_d     = send_data_q;
        send_valid_d    = send_valid_q;

        // An abort raised this very cycle counts as if already pending, so a
        // byte boundary reached now honours it.
        abort_now_s = abort_pending_q | (abort & busy_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sent_count_d    = ZERO_C;
                    abort_pending_d = 1'b0;
                    if (length != ZERO_C) begin
                        rd_ptr_d    = start_addr;
                        remaining_d = (length > DEPTH_C) ? DEPTH_C : length;
                        fill_d      = fill_mode;
                        busy_d      = 1'b1;
                        state_d     = ST_WAIT_READY;
                    end else begin
                        // Empty run: report completion without ever going busy.
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_READY: begin
                abort_pending_d = abort_now_s;
                if (abort_now_s) begin
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = ST_FINISH;
                end else if (!oled.sendDone) begin
                    // Reads the pre-write cell value when a write collides.
                    send_data_d  = fill_q ? PAD_CHAR : mem_q[rd_ptr_q];
                    send_valid_d = 1'b1;
                    state_d      = ST_SEND;
                end else begin
                    state_d = ST_WAIT_READY;
                end
            end

            ST_SEND: begin
                abort_pending_d = abort_now_s;
                if (oled.sendDone) begin
                    send_valid_d = 1'b0;
                    sent_count_d = sent_count_q + ONE_C;
                    rd_ptr_d     = rd_ptr_q + ONE_A;   // wraps modulo DEPTH
                    remaining_d  = remaining_q - ONE_C;
                    if (abort_now_s) begin
                        busy_d    = 1'b0;
                        aborted_d = 1'b1;
                        state_d   = ST_FINISH;
                    end else if (remaining_q == ONE_C) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_WAIT_READY;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            ST_FINISH: begin
                // done/aborted are high during this cycle; start is ignored.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            rd_ptr_q        <= {ADDR_W{1'b0}};
            remaining_q     <= ZERO_C;
            fill_q          <= 1'b0;
            abort_pending_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            sent_count_q    <= ZERO_C;
            send_data_q     <= 8'h00;
            send_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            remaining_q     <= remaining_d;
            fill_q          <= fill_d;
            abort_pending_q <= abort_pending_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            aborted_q       <= aborted_d;
            sent_count_q    <= sent_count_d;
            send_data_q     <= send_data_d;
            send_valid_q    <= send_valid_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign aborted            = aborted_q;
    assign sent_count         = sent_count_q;
    assign oled.sendData      = send_data_q;
    assign oled.sendDataValid = send_valid_q;

endmodule
